rsa_mod_product: RTL and testbench

//  Computes (Y * 2^K) mod N by bit-serial shift-and-reduce, where Y is a W-bit operand and N a W-bit modulus.

---
 rtl/rsa_pkg.sv | 18 +
 rtl/rsa_mod_product_mod_double_step.sv | 22 ++
 rtl/rsa_mod_product.sv | 135 +++++++++++++
 tb/tb_rsa_mod_product.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared RSA datapath definitions: operand width and the modular-product FSM states.
// Also used by the Montgomery multiplier and the exponentiation controller.
package rsa_pkg;

  localparam int RSA_W = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } modprod_state_t;

  // Cycles from an accepted start to the edge that raises out_ready
  function automatic int modprod_latency(input int w, input int k);
    return w + k;
  endfunction

endpackage

// File: rtl/rsa_mod_product_mod_double_step.sv
// One shift-and-reduce step: m_next = (2*m + bit) mod n, assuming m < n on entry.
// Purely combinational; holds the only wide add/compare/subtract of the block.
module mod_double_step #(
  parameter int W = 256
) (
  input  logic [W-1:0] m,
  input  logic         bit_in,
  input  logic [W-1:0] n,
  output logic [W-1:0] m_next
);

  logic [W:0]   w_t;
  logic         w_ge;
  logic [W-1:0] w_diff;

  // {m, bit} is exactly 2*m + bit on W+1 bits; the carry bit alone proves t >= n
  assign w_t    = {m, bit_in};
  assign w_ge   = w_t[W] | (w_t[W-1:0] >= n);
  assign w_diff = w_t[W-1:0] - n;
  assign m_next = w_ge ? w_diff : w_t[W-1:0];

endmodule

// File: rtl/rsa_mod_product.sv
// Bit-serial (Y * 2^K) mod N for mapping operands into the Montgomery domain.
// Optional macro RSA_MODPROD_CHECK_EN enables the zero-modulus error path.
module rsa_mod_product
  import rsa_pkg::*;
#(
  parameter int W     = RSA_W,
  parameter int K     = RSA_W,
  parameter int CNT_W = $clog2(W + K + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] y,
  input  logic [W-1:0] n,
  output logic         busy,
  output logic [W-1:0] out,
  output logic         out_ready,
  output logic         err
);

  modprod_state_t r_state;
  modprod_state_t w_state_next;

  logic [W-1:0]     r_ysh;
  logic [W-1:0]     r_nn;
  logic [W-1:0]     r_m;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_out;
  logic             r_out_ready;

  logic             w_accept;
  logic             w_last;
  logic             w_bit;
  logic             w_n_zero;
  logic             w_busy;
  logic [W-1:0]     w_m_next;

`ifdef RSA_MODPROD_CHECK_EN
  assign w_n_zero = (n == '0);
`else
  assign w_n_zero = 1'b0;
`endif

  assign w_accept = start && (r_state != RUN);
  assign w_last   = (r_state == RUN) && (r_cnt == CNT_W'(W + K - 1));
  // Y enters MSB first; once it is exhausted the remaining K steps double only
  assign w_bit    = (r_cnt < CNT_W'(W)) ? r_ysh[W-1] : 1'b0;

  mod_double_step #(
    .W (W)
  ) u_step (
    .m      (r_m),
    .bit_in (w_bit),
    .n      (r_nn),
    .m_next (w_m_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_next = w_n_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ysh       <= '0;
      r_nn        <= '0;
      r_m         <= '0;
      r_cnt       <= '0;
      r_out       <= '0;
      r_out_ready <= 1'b0;
    end else if (w_accept) begin
      r_ysh       <= y;
      r_nn        <= n;
      r_m         <= '0;
      r_cnt       <= '0;
      r_out_ready <= w_n_zero;
      if (w_n_zero) begin
        r_out <= '0;
      end
    end else if (r_state == RUN) begin
      r_ysh <= r_ysh << 1;
      r_m   <= w_m_next;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_out       <= w_m_next;
        r_out_ready <= 1'b1;
      end
    end
  end

`ifdef RSA_MODPROD_CHECK_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= w_n_zero;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign busy      = w_busy;
  assign out       = r_out;
  assign out_ready = r_out_ready;

endmodule

// File: tb/tb_rsa_mod_product.sv
// Scoreboard bench for rsa_mod_product: a W=K=8 instance for directed corner cases and a
// default W=K=256 instance for random operands, both checked against wide-integer arithmetic.
module tb_rsa_mod_product;

  localparam int SW = 8;
  localparam int SK = 8;
  localparam int BW = 256;
  localparam int BK = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start_s = 1'b0;
  logic [SW-1:0] y_s = '0;
  logic [SW-1:0] n_s = '0;
  logic          busy_s;
  logic [SW-1:0] out_s;
  logic          rdy_s;
  logic          err_s;

  logic          start_b = 1'b0;
  logic [BW-1:0] y_b = '0;
  logic [BW-1:0] n_b = '0;
  logic          busy_b;
  logic [BW-1:0] out_b;
  logic          rdy_b;
  logic          err_b;

  rsa_mod_product #(.W(SW), .K(SK)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_s), .y(y_s), .n(n_s),
    .busy(busy_s), .out(out_s), .out_ready(rdy_s), .err(err_s)
  );

  rsa_mod_product u_big (
    .clk(clk), .rst_n(rst_n), .start(start_b), .y(y_b), .n(n_b),
    .busy(busy_b), .out(out_b), .out_ready(rdy_b), .err(err_b)
  );

  typedef struct {
    logic [BW-1:0] y;
    logic [BW-1:0] n;
    logic [BW-1:0] exp_out;
    logic          exp_err;
    bit            chk_out;
    int            accept_cyc;
    int            exp_lat;
  } exp_t;

  exp_t sb_s[$];
  exp_t sb_b[$];
  exp_t es;
  exp_t eb;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic prev_s = 1'b0;
  logic prev_b = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: (Y * 2^K) mod N with plain wide arithmetic
  function automatic logic [BW-1:0] ref_mod(input logic [BW-1:0] y, input logic [BW-1:0] n,
                                            input int k);
    logic [2*BW-1:0] num;
    logic [2*BW-1:0] r;
    num = {{BW{1'b0}}, y} << k;
    r   = num % {{BW{1'b0}}, n};
    return r[BW-1:0];
  endfunction

  function automatic exp_t make_exp(input logic [BW-1:0] y, input logic [BW-1:0] n,
                                    input int w, input int k, input int acc);
    exp_t e;
    e.y = y; e.n = n; e.accept_cyc = acc;
    e.exp_err = 1'b0; e.chk_out = 1'b1; e.exp_lat = w + k; e.exp_out = '0;
    if (n == '0) begin
`ifdef RSA_MODPROD_CHECK_EN
      e.exp_err = 1'b1;
      e.exp_lat = 0;
`else
      e.chk_out = 1'b0;
`endif
    end else begin
      e.exp_out = ref_mod(y, n, k);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rdy_s && !prev_s) begin
      if (sb_s.size() == 0) begin
        checks++; errors++;
        $display("FAIL small_unexpected: out_ready rose with no job pending, out=%0d", out_s);
      end else begin
        es = sb_s.pop_front();
        checks++;
        if (es.chk_out && out_s !== es.exp_out[SW-1:0]) begin
          errors++;
          $display("FAIL small_out: y=%0d n=%0d out=%0d expected %0d", es.y, es.n, out_s, es.exp_out);
        end
        checks++;
        if (err_s !== es.exp_err || (cyc - es.accept_cyc) != es.exp_lat) begin
          errors++;
          $display("FAIL small_err_lat: y=%0d n=%0d err=%0b lat=%0d expected err=%0b lat=%0d",
                   es.y, es.n, err_s, cyc - es.accept_cyc, es.exp_err, es.exp_lat);
        end
        $display("small job y=%0d n=%0d out=%0d err=%0b lat=%0d", es.y, es.n, out_s, err_s,
                 cyc - es.accept_cyc);
      end
    end
    prev_s <= rdy_s;
  end

  always @(negedge clk) begin
    if (rdy_b && !prev_b) begin
      if (sb_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL big_unexpected: out_ready rose with no job pending, out=%h", out_b);
      end else begin
        eb = sb_b.pop_front();
        checks++;
        if (eb.chk_out && out_b !== eb.exp_out) begin
          errors++;
          $display("FAIL big_out: n=%h out=%h expected %h", eb.n, out_b, eb.exp_out);
        end
        checks++;
        if (err_b !== eb.exp_err || (cyc - eb.accept_cyc) != eb.exp_lat) begin
          errors++;
          $display("FAIL big_err_lat: err=%0b lat=%0d expected err=%0b lat=%0d",
                   err_b, cyc - eb.accept_cyc, eb.exp_err, eb.exp_lat);
        end
        $display("big job n=%h out=%h lat=%0d", eb.n, out_b, cyc - eb.accept_cyc);
      end
    end
    prev_b <= rdy_b;
  end

  task automatic issue_s(input logic [SW-1:0] y, input logic [SW-1:0] n);
    y_s = y; n_s = n; start_s = 1'b1;
    sb_s.push_back(make_exp(BW'(y), BW'(n), SW, SK, cyc + 1));
    @(negedge clk);
    start_s = 1'b0;
  endtask

  task automatic issue_b(input logic [BW-1:0] y, input logic [BW-1:0] n);
    y_b = y; n_b = n; start_b = 1'b1;
    sb_b.push_back(make_exp(y, n, BW, BK, cyc + 1));
    @(negedge clk);
    start_b = 1'b0;
  endtask

  task automatic wait_s(input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      @(negedge clk);
      if (sb_s.size() == 0) break;
    end
    if (i == limit) begin
      checks++; errors++;
      $display("FAIL small_timeout: %0d jobs still pending after %0d cycles, required 0", sb_s.size(), limit);
      sb_s.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_b(input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      @(negedge clk);
      if (sb_b.size() == 0) break;
    end
    if (i == limit) begin
      checks++; errors++;
      $display("FAIL big_timeout: %0d jobs still pending after %0d cycles, required 0", sb_b.size(), limit);
      sb_b.delete();
    end
    @(negedge clk);
  endtask

  function automatic logic [BW-1:0] rand_wide();
    logic [BW-1:0] v;
    for (int i = 0; i < BW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic check_idle(input string tag);
    checks++;
    if (busy_s !== 1'b0 || out_s !== '0 || rdy_s !== 1'b0 || err_s !== 1'b0 ||
        busy_b !== 1'b0 || out_b !== '0 || rdy_b !== 1'b0 || err_b !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy=%0b/%0b out=%0d/%h ready=%0b/%0b err=%0b/%0b, required all zero",
               tag, busy_s, busy_b, out_s, out_b, rdy_s, rdy_b, err_s, err_b);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cnt;
    int acc0;
    logic [BW-1:0] ry;
    logic [BW-1:0] rn;

    repeat (3) @(negedge clk);
    check_idle("reset_state");
    rst_n = 1'b1;
    @(negedge clk);

    // 5 * 256 mod 7 = 6, with busy counted while the job runs
    issue_s(8'd5, 8'd7);
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (rdy_s) break;
      busy_cnt += int'(busy_s);
      @(negedge clk);
    end
    checks++;
    if (busy_cnt != SW + SK) begin
      errors++;
      $display("FAIL busy_cycles: busy high %0d cycles, required %0d", busy_cnt, SW + SK);
    end
    wait_s(60);

    issue_s(8'd200, 8'd13); wait_s(60);
    issue_s(8'd255, 8'd1);  wait_s(60);
    issue_s(8'd0, 8'd251);  wait_s(60);
    issue_s(8'd255, 8'd255); wait_s(60);

    for (int j = 0; j < 20; j++) begin
      issue_s(SW'($urandom_range(0, 255)), SW'($urandom_range(1, 255)));
      wait_s(60);
    end

    // start held high: three back-to-back jobs, one every W+K+1 cycles
    y_s = 8'd9; n_s = 8'd11; start_s = 1'b1;
    acc0 = cyc + 1;
    for (int j = 0; j < 3; j++) sb_s.push_back(make_exp(BW'(9), BW'(11), SW, SK, acc0 + j * (SW + SK + 1)));
    repeat (40) @(negedge clk);
    start_s = 1'b0;
    wait_s(60);

    // a second start during RUN must be ignored
    issue_s(8'd100, 8'd97);
    repeat (4) @(negedge clk);
    y_s = 8'd3; n_s = 8'd5; start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    wait_s(60);

    // reset in the middle of a job: outputs clear immediately, result is discarded
    issue_s(8'd200, 8'd13); wait_s(60);
    issue_s(8'd77, 8'd131);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb_s.delete();
    check_idle("async_reset_mid_run");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue_s(8'd37, 8'd0);    wait_s(60);
    issue_s(8'd200, 8'd13);  wait_s(60);

    // full-width instance: fixed corners then random odd moduli
    issue_b({BW{1'b1}}, 256'd3);          wait_b(600);
    issue_b({BW{1'b1}}, {BW{1'b1}});      wait_b(600);
    issue_b(256'd1, {1'b1, 255'd1});      wait_b(600);
    for (int j = 0; j < 30; j++) begin
      ry = rand_wide();
      rn = rand_wide() | BW'(1);
      if (j % 5 == 0) rn = rn >> $urandom_range(1, 200);
      rn[0] = 1'b1;
      issue_b(ry, rn);
      wait_b(600);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
